fdtd_reg_burst_rd: RTL and testbench
====================================

Name: fdtd_reg_burst_rd

Overview:
AXI4 read-slave to word-register adapter for the FDTD user plugin. It is the burst-capable successor of the single-data read adapter.
- Fetches a fresh register word per beat, with per-beat address sequencing for FIXED/INCR/WRAP bursts.
- Supports a configurable register-file read latency.
- Returns per-beat error responses for unmapped words and illegal requests.
- Sits between the plugin AXI slave port and the FDTD control/status register file; one transaction in flight.

Parameters:
AXI4_ADDR_WIDTH, 32, AR address width
AXI4_DATA_WIDTH, 32, R data width; word = AXI4_DATA_WIDTH/8 bytes
AXI4_ID_WIDTH, 16, ID width
AXI4_USER_WIDTH, 10, user width
WORD_ADDR_WIDTH, 4, register word-address width
NUM_WORDS, 16, implemented words (1..2**WORD_ADDR_WIDTH); word addresses >= NUM_WORDS are unmapped
RD_LATENCY, 0, cycles from avalid_o to data_i valid (0..3)

Ports:
ACLK  in  1  clock
ARESETn  in  1  asynchronous active-low reset
ARID_i  in  AXI4_ID_WIDTH  read ID
ARADDR_i  in  AXI4_ADDR_WIDTH  byte address; word address = ARADDR_i[WORD_ADDR_WIDTH+1:2]
ARLEN_i  in  8  beats-1
ARSIZE_i  in  3  beat size
ARBURST_i  in  2  burst type
ARLOCK_i, ARCACHE_i, ARPROT_i, ARREGION_i, ARQOS_i, ARUSER_i  in  std widths  ignored
ARVALID_i  in  1  AR valid
ARREADY_o  out  1  AR ready
RID_o  out  AXI4_ID_WIDTH  latched ARID
RDATA_o  out  AXI4_DATA_WIDTH  beat data
RRESP_o  out  2  beat response
RLAST_o  out  1  last beat
RUSER_o  out  AXI4_USER_WIDTH  tied 0
RVALID_o  out  1  R valid
RREADY_i  in  1  R ready
avalid_o  out  1  one-cycle register read strobe
word_addr_o  out  WORD_ADDR_WIDTH  word address for current beat
data_i  in  AXI4_DATA_WIDTH  register data, valid RD_LATENCY cycles after avalid_o

Behaviour:
- Reset:
  - ARESETn low forces state IDLE.
  - ARREADY_o, RVALID_o, RLAST_o, avalid_o, RID_o, RDATA_o, RRESP_o, word_addr_o and all counters are 0.
  - ARREADY_o is registered. It rises on the first ACLK edge after reset release.
  - Reset mid-burst aborts the burst immediately; no further R beats are issued.
- States:
  - IDLE: ARREADY_o=1. On ARVALID_i, latch ARID, ARLEN, ARBURST, word address, and the error flag. ARREADY_o drops next cycle. Go to FETCH.
  - FETCH: one cycle. avalid_o=1 if the beat is mapped and the request is legal, else 0. Load the latency counter with RD_LATENCY. If RD_LATENCY=0, sample data_i at the end of this cycle and go to SEND; else go to WAIT.
  - WAIT: decrement the counter. When it reaches 1, sample data_i at the end of the cycle and go to SEND.
  - SEND: RVALID_o=1 and RLAST_o=(beat counter==0). RDATA_o and RRESP_o are held stable until RREADY_i.
    - On RREADY_i with beats remaining: decrement the beat counter, advance the address, go to FETCH.
    - On RREADY_i on the last beat: go to IDLE; ARREADY_o is 1 the following cycle.
- Timing: AR handshake at cycle T gives avalid_o at T+1 and RVALID_o at T+2+RD_LATENCY. Steady-state throughput is one beat per 2+RD_LATENCY cycles with RREADY_i held high.
- Address sequencing is word-granular, computed in WORD_ADDR_WIDTH bits:
  - FIXED: address constant.
  - INCR: +1 per beat, wrapping modulo 2**WORD_ADDR_WIDTH.
  - WRAP: +1 within an aligned window of ARLEN+1 words.
- Illegal requests (flag latched at AR, affects all beats):
  - ARBURST=2'b11.
  - WRAP with ARLEN not in {1,3,7,15}.
  - ARSIZE != log2(AXI4_DATA_WIDTH/8).
  - Response: RRESP=SLVERR, RDATA=0, no avalid_o, full ARLEN+1 beats still returned with correct RLAST_o.
- Unmapped beat (legal request, word address >= NUM_WORDS): that beat returns RRESP=DECERR and RDATA=0 with no avalid_o. Other beats return OKAY.
- Beat counter is 8 bits, so ARLEN=255 yields 256 beats.
- RID_o is constant for the whole burst.

Decomposition:
- Shared package fdtd_axi_pkg:
  - RESP_OKAY/EXOKAY/SLVERR/DECERR constants.
  - BURST_FIXED/INCR/WRAP constants.
  - rd_state_t enum {IDLE, FETCH, WAIT, SEND}.
- One sub-module, fdtd_burst_addr_gen: combinational next word address from (addr, burst, len). It is unit-tested separately.

Test Plan:
- Single beat, ARADDR=0x08, ARLEN=0, INCR, data_i=0xA5A5_0002 -> avalid_o with word_addr_o=2 at T+1; RVALID/RLAST at T+2 with RDATA=0xA5A5_0002, RRESP=OKAY.
- INCR, ARADDR=0x04, ARLEN=3, RREADY_i low 3 cycles on beat 1 -> word_addr_o sequence 1,2,3,4; RDATA held during stall; RLAST only on 4th beat.
- WRAP, ARADDR=0x08, ARLEN=3 -> word_addr_o 2,3,0,1. FIXED, ARLEN=2 -> 3 strobes, all to the same word.
- NUM_WORDS=12, INCR from word 10, ARLEN=3 -> RRESP OKAY,OKAY,DECERR,DECERR; avalid_o only on first two beats; RDATA=0 on DECERR beats.
- ARBURST=2'b11, ARLEN=1 -> 2 beats of SLVERR, no avalid_o. WRAP with ARLEN=2 -> 3 beats of SLVERR.
- RD_LATENCY=2: RVALID at T+4. Assert ARESETn low during beat 2 of a 4-beat burst -> all outputs 0 immediately; ARREADY_o=1 one cycle after release; a new single-beat read completes normally.

Source files
------------

// File: rtl/fdtd_axi_pkg.sv
// Shared AXI4 constants and read-FSM state type for the FDTD plugin register adapters.
package fdtd_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        SEND  = 2'd3
    } rd_state_t;

    // A WRAP burst must cover a power-of-two window of 2..16 beats.
    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/fdtd_burst_addr_gen.sv
// Combinational next word address for one AXI4 burst beat (FIXED / INCR / WRAP).
module fdtd_burst_addr_gen
    import fdtd_axi_pkg::*;
#(
    parameter int WORD_ADDR_WIDTH = 4
)(
    input  logic [WORD_ADDR_WIDTH-1:0] addr,
    input  logic [1:0]                 burst,
    input  logic [7:0]                 len,
    output logic [WORD_ADDR_WIDTH-1:0] next_addr
);

    logic [WORD_ADDR_WIDTH-1:0] mask_s;
    logic [WORD_ADDR_WIDTH-1:0] incr_s;

    // For a legal WRAP, len is 2**k-1, so it doubles as the low-bit window mask.
    always_comb begin
        mask_s = WORD_ADDR_WIDTH'(len);
        incr_s = addr + WORD_ADDR_WIDTH'(1'b1);
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_INCR:  next_addr = incr_s;
            BURST_WRAP:  next_addr = (addr & ~mask_s) | (incr_s & mask_s);
            default:     next_addr = addr;
        endcase
    end

endmodule

// File: rtl/fdtd_reg_burst_rd.sv
// AXI4 burst read slave in front of the FDTD word register file; fetches one
// register word per beat with a fixed read latency, one transaction in flight.
module fdtd_reg_burst_rd
    import fdtd_axi_pkg::*;
#(
    parameter int AXI4_ADDR_WIDTH = 32,
    parameter int AXI4_DATA_WIDTH = 32,
    parameter int AXI4_ID_WIDTH   = 16,
    parameter int AXI4_USER_WIDTH = 10,
    parameter int WORD_ADDR_WIDTH = 4,
    parameter int NUM_WORDS       = 16,
    parameter int RD_LATENCY      = 0
)(
    input  logic                       ACLK,
    input  logic                       ARESETn,
    input  logic [AXI4_ID_WIDTH-1:0]   ARID_i,
    input  logic [AXI4_ADDR_WIDTH-1:0] ARADDR_i,
    input  logic [7:0]                 ARLEN_i,
    input  logic [2:0]                 ARSIZE_i,
    input  logic [1:0]                 ARBURST_i,
    input  logic                       ARLOCK_i,
    input  logic [3:0]                 ARCACHE_i,
    input  logic [2:0]                 ARPROT_i,
    input  logic [3:0]                 ARREGION_i,
    input  logic [3:0]                 ARQOS_i,
    input  logic [AXI4_USER_WIDTH-1:0] ARUSER_i,
    input  logic                       ARVALID_i,
    output logic                       ARREADY_o,
    output logic [AXI4_ID_WIDTH-1:0]   RID_o,
    output logic [AXI4_DATA_WIDTH-1:0] RDATA_o,
    output logic [1:0]                 RRESP_o,
    output logic                       RLAST_o,
    output logic [AXI4_USER_WIDTH-1:0] RUSER_o,
    output logic                       RVALID_o,
    input  logic                       RREADY_i,
    output logic                       avalid_o,
    output logic [WORD_ADDR_WIDTH-1:0] word_addr_o,
    input  logic [AXI4_DATA_WIDTH-1:0] data_i
);

    localparam logic [2:0] SIZE_LEGAL = 3'($clog2(AXI4_DATA_WIDTH / 8));
    localparam logic [1:0] LAT_INIT   = 2'(RD_LATENCY);

    rd_state_t                  state_r;
    logic                       arready_r;
    logic                       rvalid_r;
    logic                       rlast_r;
    logic                       avalid_r;
    logic [AXI4_ID_WIDTH-1:0]   rid_r;
    logic [AXI4_DATA_WIDTH-1:0] rdata_r;
    logic [1:0]                 rresp_r;
    logic [WORD_ADDR_WIDTH-1:0] addr_r;
    logic [7:0]                 beats_r;
    logic [7:0]                 len_r;
    logic [1:0]                 burst_r;
    logic                       err_r;
    logic [1:0]                 lat_r;

    logic [WORD_ADDR_WIDTH-1:0] ar_addr_s;
    logic                       ar_err_s;
    logic [WORD_ADDR_WIDTH-1:0] next_addr_s;
    logic [1:0]                 beat_resp_s;
    logic [AXI4_DATA_WIDTH-1:0] beat_data_s;
    logic                       unused_s;

    function automatic logic is_mapped(input logic [WORD_ADDR_WIDTH-1:0] a);
        return 32'(a) < 32'(NUM_WORDS);
    endfunction

    assign ar_addr_s = ARADDR_i[WORD_ADDR_WIDTH+1:2];
    assign ar_err_s  = (ARBURST_i == 2'b11)
                     || ((ARBURST_i == BURST_WRAP) && !wrap_len_ok(ARLEN_i))
                     || (ARSIZE_i != SIZE_LEGAL);
    assign unused_s  = ^{ARLOCK_i, ARCACHE_i, ARPROT_i, ARREGION_i, ARQOS_i, ARUSER_i,
                         ARADDR_i[AXI4_ADDR_WIDTH-1:WORD_ADDR_WIDTH+2], ARADDR_i[1:0]};

    fdtd_burst_addr_gen #(
        .WORD_ADDR_WIDTH (WORD_ADDR_WIDTH)
    ) u_addr_gen (
        .addr      (addr_r),
        .burst     (burst_r),
        .len       (len_r),
        .next_addr (next_addr_s)
    );

    // Response for the beat currently addressed; errored beats never expose register data.
    always_comb begin
        if (err_r) begin
            beat_resp_s = RESP_SLVERR;
        end else if (is_mapped(addr_r)) begin
            beat_resp_s = RESP_OKAY;
        end else begin
            beat_resp_s = RESP_DECERR;
        end
        if (beat_resp_s == RESP_OKAY) begin
            beat_data_s = data_i;
        end else begin
            beat_data_s = {AXI4_DATA_WIDTH{1'b0}};
        end
    end

    // Read FSM: AR accept, register strobe, latency wait, R beat hold.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_r   <= IDLE;
            arready_r <= 1'b0;
            rvalid_r  <= 1'b0;
            rlast_r   <= 1'b0;
            avalid_r  <= 1'b0;
            rid_r     <= {AXI4_ID_WIDTH{1'b0}};
            rdata_r   <= {AXI4_DATA_WIDTH{1'b0}};
            rresp_r   <= RESP_OKAY;
            addr_r    <= {WORD_ADDR_WIDTH{1'b0}};
            beats_r   <= 8'd0;
            len_r     <= 8'd0;
            burst_r   <= BURST_FIXED;
            err_r     <= 1'b0;
            lat_r     <= 2'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (ARVALID_i && arready_r) begin
                        arready_r <= 1'b0;
                        rid_r     <= ARID_i;
                        len_r     <= ARLEN_i;
                        beats_r   <= ARLEN_i;
                        burst_r   <= ARBURST_i;
                        err_r     <= ar_err_s;
                        addr_r    <= ar_addr_s;
                        avalid_r  <= !ar_err_s && is_mapped(ar_addr_s);
                        state_r   <= FETCH;
                    end else begin
                        arready_r <= 1'b1;
                    end
                end
                FETCH: begin
                    avalid_r <= 1'b0;
                    if (LAT_INIT == 2'd0) begin
                        rvalid_r <= 1'b1;
                        rlast_r  <= (beats_r == 8'd0);
                        rresp_r  <= beat_resp_s;
                        rdata_r  <= beat_data_s;
                        state_r  <= SEND;
                    end else begin
                        lat_r   <= LAT_INIT;
                        state_r <= WAIT;
                    end
                end
                WAIT: begin
                    if (lat_r == 2'd1) begin
                        rvalid_r <= 1'b1;
                        rlast_r  <= (beats_r == 8'd0);
                        rresp_r  <= beat_resp_s;
                        rdata_r  <= beat_data_s;
                        state_r  <= SEND;
                    end else begin
                        lat_r <= lat_r - 2'd1;
                    end
                end
                SEND: begin
                    if (RREADY_i) begin
                        rvalid_r <= 1'b0;
                        rlast_r  <= 1'b0;
                        if (beats_r != 8'd0) begin
                            beats_r  <= beats_r - 8'd1;
                            addr_r   <= next_addr_s;
                            avalid_r <= !err_r && is_mapped(next_addr_s);
                            state_r  <= FETCH;
                        end else begin
                            arready_r <= 1'b1;
                            state_r   <= IDLE;
                        end
                    end else begin
                        rvalid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign ARREADY_o   = arready_r;
    assign RID_o       = rid_r;
    assign RDATA_o     = rdata_r;
    assign RRESP_o     = rresp_r;
    assign RLAST_o     = rlast_r;
    assign RUSER_o     = {AXI4_USER_WIDTH{1'b0}};
    assign RVALID_o    = rvalid_r;
    assign avalid_o    = avalid_r;
    assign word_addr_o = addr_r;

endmodule

// File: tb/tb_fdtd_reg_burst_rd.sv
// Bench for fdtd_reg_burst_rd: two instances (12 words / latency 0, 16 words / latency 2)
// driven in lockstep and checked every cycle against a transaction-level model.
module tb_fdtd_reg_burst_rd;

    localparam int NLANE = 2;
    localparam int DEPTH = 300;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [15:0] arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic [3:0]  arregion;
    logic [3:0]  arqos;
    logic [9:0]  aruser;

    logic        arvalid [NLANE];
    logic        arready [NLANE];
    logic        rvalid  [NLANE];
    logic        rlast   [NLANE];
    logic        rready  [NLANE];
    logic        avalid  [NLANE];
    logic [15:0] rid     [NLANE];
    logic [31:0] rdata   [NLANE];
    logic [1:0]  rresp   [NLANE];
    logic [9:0]  ruser   [NLANE];
    logic [3:0]  waddr   [NLANE];
    logic [31:0] data_in0, data_in1;
    logic        p1_v, p2_v;
    logic [3:0]  p1_a, p2_a;

    always #5 aclk = ~aclk;

    function automatic logic [31:0] rf(input int w);
        return 32'hA5A5_0000 | 32'(w);
    endfunction

    // Register file emulation: data is only valid exactly RD_LATENCY cycles after a strobe.
    always_comb data_in0 = avalid[0] ? rf(int'(waddr[0])) : 32'hBAD0_0000;
    always_comb data_in1 = p2_v ? rf(int'(p2_a)) : 32'hBAD1_1111;
    always @(posedge aclk) begin
        p1_v <= avalid[1];
        p1_a <= waddr[1];
        p2_v <= p1_v;
        p2_a <= p1_a;
    end

    fdtd_reg_burst_rd #(.NUM_WORDS(12), .RD_LATENCY(0)) dut0 (
        .ACLK(aclk), .ARESETn(aresetn), .ARID_i(arid), .ARADDR_i(araddr), .ARLEN_i(arlen),
        .ARSIZE_i(arsize), .ARBURST_i(arburst), .ARLOCK_i(arlock), .ARCACHE_i(arcache),
        .ARPROT_i(arprot), .ARREGION_i(arregion), .ARQOS_i(arqos), .ARUSER_i(aruser),
        .ARVALID_i(arvalid[0]), .ARREADY_o(arready[0]), .RID_o(rid[0]), .RDATA_o(rdata[0]),
        .RRESP_o(rresp[0]), .RLAST_o(rlast[0]), .RUSER_o(ruser[0]), .RVALID_o(rvalid[0]),
        .RREADY_i(rready[0]), .avalid_o(avalid[0]), .word_addr_o(waddr[0]), .data_i(data_in0)
    );

    fdtd_reg_burst_rd #(.NUM_WORDS(16), .RD_LATENCY(2)) dut1 (
        .ACLK(aclk), .ARESETn(aresetn), .ARID_i(arid), .ARADDR_i(araddr), .ARLEN_i(arlen),
        .ARSIZE_i(arsize), .ARBURST_i(arburst), .ARLOCK_i(arlock), .ARCACHE_i(arcache),
        .ARPROT_i(arprot), .ARREGION_i(arregion), .ARQOS_i(arqos), .ARUSER_i(aruser),
        .ARVALID_i(arvalid[1]), .ARREADY_o(arready[1]), .RID_o(rid[1]), .RDATA_o(rdata[1]),
        .RRESP_o(rresp[1]), .RLAST_o(rlast[1]), .RUSER_o(ruser[1]), .RVALID_o(rvalid[1]),
        .RREADY_i(rready[1]), .avalid_o(avalid[1]), .word_addr_o(waddr[1]), .data_i(data_in1)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [31:0] e_data [NLANE][DEPTH];
    logic [1:0]  e_resp [NLANE][DEPTH];
    logic        e_last [NLANE][DEPTH];
    logic [15:0] e_id   [NLANE][DEPTH];
    int          s_addr [NLANE][DEPTH];
    int          eh [NLANE], et [NLANE], sh [NLANE], st [NLANE];
    bit          busy [NLANE], prev_rv [NLANE], ar_hs [NLANE];
    int          next_rv [NLANE], beats_done [NLANE], stall_cnt [NLANE];
    logic [31:0] last_rdata [NLANE];
    bit          post_rst;

    function automatic int lat(input int ln);
        return (ln == 0) ? 0 : 2;
    endfunction

    function automatic int nwords(input int ln);
        return (ln == 0) ? 12 : 16;
    endfunction

    // Word address of beat i of a burst of n beats starting at word a0 (16-word space).
    function automatic int model_addr(input int a0, input logic [1:0] burst, input int n, input int i);
        int base;
        case (burst)
            2'b00:   return a0;
            2'b01:   return (a0 + i) % 16;
            2'b10: begin
                base = (a0 / n) * n;
                return base + (a0 - base + i) % n;
            end
            default: return a0;
        endcase
    endfunction

    task automatic chk(input string name, input int ln, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s lane%0d at cycle %0d: actual=%0h required=%0h", name, ln, cyc, act, exp);
        end
    endtask

    task automatic push_txn(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [15:0] id);
        int  a0, n, w;
        bit  illegal;
        logic [1:0] resp;
        a0 = int'(addr[5:2]);
        n  = int'(len) + 1;
        illegal = (burst == 2'b11) || (size != 3'd2)
               || ((burst == 2'b10) && !(n == 2 || n == 4 || n == 8 || n == 16));
        for (int ln = 0; ln < NLANE; ln++) begin
            eh[ln] = 0; et[ln] = 0; sh[ln] = 0; st[ln] = 0;
            beats_done[ln] = 0; stall_cnt[ln] = 0;
            for (int i = 0; i < n; i++) begin
                w = model_addr(a0, burst, n, i);
                resp = illegal ? 2'b10 : ((w < nwords(ln)) ? 2'b00 : 2'b11);
                e_data[ln][i] = (resp == 2'b00) ? rf(w) : 32'h0;
                e_resp[ln][i] = resp;
                e_last[ln][i] = (i == n - 1);
                e_id[ln][i]   = id;
                if (resp == 2'b00) begin
                    s_addr[ln][st[ln]] = w;
                    st[ln]++;
                end
            end
            et[ln] = n;
        end
    endtask

    task automatic compare();
        for (int ln = 0; ln < NLANE; ln++) begin
            chk("arready", ln, 64'(arready[ln]), 64'(!busy[ln] && !post_rst));
            ar_hs[ln] = arvalid[ln] && arready[ln];
            if (ar_hs[ln]) begin
                busy[ln]    = 1'b1;
                next_rv[ln] = cyc + 2 + lat(ln);
            end
            if (avalid[ln]) begin
                if (sh[ln] == st[ln]) begin
                    chk("spurious_strobe", ln, 64'(avalid[ln]), 64'(0));
                end else begin
                    chk("strobe_addr", ln, 64'(waddr[ln]), 64'(s_addr[ln][sh[ln]]));
                    chk("strobe_time", ln, 64'(cyc), 64'(next_rv[ln] - 1 - lat(ln)));
                    sh[ln]++;
                end
            end
            if (eh[ln] == et[ln]) begin
                chk("rvalid_idle", ln, 64'(rvalid[ln]), 64'(0));
            end else if (rvalid[ln]) begin
                if (!prev_rv[ln]) chk("rvalid_time", ln, 64'(cyc), 64'(next_rv[ln]));
                chk("rdata", ln, 64'(rdata[ln]), 64'(e_data[ln][eh[ln]]));
                chk("rresp", ln, 64'(rresp[ln]), 64'(e_resp[ln][eh[ln]]));
                chk("rlast", ln, 64'(rlast[ln]), 64'(e_last[ln][eh[ln]]));
                chk("rid",   ln, 64'(rid[ln]),   64'(e_id[ln][eh[ln]]));
                chk("ruser", ln, 64'(ruser[ln]), 64'(0));
                if (rready[ln]) begin
                    last_rdata[ln] = rdata[ln];
                    if (e_last[ln][eh[ln]]) busy[ln] = 1'b0;
                    else next_rv[ln] = cyc + 2 + lat(ln);
                    eh[ln]++;
                    beats_done[ln]++;
                end else if (beats_done[ln] == 1) begin
                    stall_cnt[ln]++;
                end
            end
            prev_rv[ln] = rvalid[ln];
        end
        post_rst = 1'b0;
    endtask

    task automatic tick();
        @(negedge aclk);
        if (aresetn) compare();
        @(posedge aclk);
        cyc++;
        #1;
    endtask

    function automatic logic pick_ready(input int mode, input int ln);
        case (mode)
            0:       return 1'b1;
            1:       return ($urandom_range(0, 3) != 0);
            default: return !(beats_done[ln] == 1 && stall_cnt[ln] < 3);
        endcase
    endfunction

    task automatic start_txn(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                             input logic [1:0] burst, input logic [15:0] id, input int mode);
        push_txn(addr, len, size, burst, id);
        araddr = addr; arlen = len; arsize = size; arburst = burst; arid = id;
        arcache = 4'($urandom); arprot = 3'($urandom); aruser = 10'($urandom);
        for (int ln = 0; ln < NLANE; ln++) begin
            arvalid[ln] = 1'b1;
            rready[ln]  = pick_ready(mode, ln);
        end
    endtask

    task automatic wait_done(input int mode);
        int guard = 0;
        while ((busy[0] || busy[1] || arvalid[0] || arvalid[1]) && guard < 3000) begin
            tick();
            guard++;
            for (int ln = 0; ln < NLANE; ln++) begin
                if (ar_hs[ln]) arvalid[ln] = 1'b0;
                rready[ln] = pick_ready(mode, ln);
            end
        end
        chk("txn_completes", 0, 64'(guard < 3000), 64'(1));
        for (int ln = 0; ln < NLANE; ln++) begin
            chk("strobes_left", ln, 64'(st[ln] - sh[ln]), 64'(0));
            chk("beats_left",   ln, 64'(et[ln] - eh[ln]), 64'(0));
            arvalid[ln] = 1'b0;
            busy[ln]    = 1'b0;
        end
    endtask

    task automatic run_txn(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [15:0] id, input int mode);
        start_txn(addr, len, size, burst, id, mode);
        wait_done(mode);
    endtask

    task automatic check_reset_outputs();
        for (int ln = 0; ln < NLANE; ln++) begin
            chk("rst_arready", ln, 64'(arready[ln]), 64'(0));
            chk("rst_rvalid",  ln, 64'(rvalid[ln]),  64'(0));
            chk("rst_rlast",   ln, 64'(rlast[ln]),   64'(0));
            chk("rst_avalid",  ln, 64'(avalid[ln]),  64'(0));
            chk("rst_rid",     ln, 64'(rid[ln]),     64'(0));
            chk("rst_rdata",   ln, 64'(rdata[ln]),   64'(0));
            chk("rst_rresp",   ln, 64'(rresp[ln]),   64'(0));
            chk("rst_waddr",   ln, 64'(waddr[ln]),   64'(0));
        end
    endtask

    task automatic clear_model();
        for (int ln = 0; ln < NLANE; ln++) begin
            eh[ln] = 0; et[ln] = 0; sh[ln] = 0; st[ln] = 0;
            busy[ln] = 1'b0; prev_rv[ln] = 1'b0; arvalid[ln] = 1'b0; ar_hs[ln] = 1'b0;
        end
    endtask

    initial begin
        logic [1:0] bt;
        logic [7:0] ln8;
        logic [2:0] sz;
        int         k;
        aresetn = 1'b0;
        arid = 16'h0; araddr = 32'h0; arlen = 8'h0; arsize = 3'd2; arburst = 2'b01;
        arlock = 1'b0; arcache = 4'h0; arprot = 3'h0; arregion = 4'h0; arqos = 4'h0; aruser = 10'h0;
        clear_model();
        for (int ln = 0; ln < NLANE; ln++) rready[ln] = 1'b0;
        post_rst = 1'b0;
        #2;
        check_reset_outputs();
        repeat (3) @(posedge aclk);
        #1;
        aresetn  = 1'b1;
        post_rst = 1'b1;

        // Model pins against hand-computed sequences.
        chk("pin_wrap0", 0, 64'(model_addr(2, 2'b10, 4, 0)), 64'(2));
        chk("pin_wrap2", 0, 64'(model_addr(2, 2'b10, 4, 2)), 64'(0));
        chk("pin_wrap3", 0, 64'(model_addr(2, 2'b10, 4, 3)), 64'(1));
        chk("pin_incr_wrap", 0, 64'(model_addr(15, 2'b01, 2, 1)), 64'(0));

        run_txn(32'h0000_0008, 8'd0, 3'd2, 2'b01, 16'h1234, 0);
        chk("single_rdata_lit", 0, 64'(last_rdata[0]), 64'(32'hA5A5_0002));
        chk("single_rdata_lit", 1, 64'(last_rdata[1]), 64'(32'hA5A5_0002));

        run_txn(32'h0000_0004, 8'd3, 3'd2, 2'b01, 16'h00AB, 2);
        chk("incr_last_data", 0, 64'(last_rdata[0]), 64'(32'hA5A5_0004));
        run_txn(32'h0000_0008, 8'd3, 3'd2, 2'b10, 16'h0C0D, 0);
        chk("wrap_last_data", 1, 64'(last_rdata[1]), 64'(32'hA5A5_0001));

        start_txn(32'h0000_000C, 8'd2, 3'd2, 2'b00, 16'h0F0F, 1);
        chk("fixed_strobes", 0, 64'(st[0]), 64'(3));
        wait_done(1);

        start_txn(32'h0000_0028, 8'd3, 3'd2, 2'b01, 16'h0D0E, 0);
        chk("unmapped_strobes", 0, 64'(st[0]), 64'(2));
        chk("unmapped_resp2", 0, 64'(e_resp[0][2]), 64'(2'b11));
        wait_done(0);

        run_txn(32'h0000_0000, 8'd1, 3'd2, 2'b11, 16'h0BAD, 0);
        run_txn(32'h0000_0000, 8'd2, 3'd2, 2'b10, 16'h0BAE, 1);
        run_txn(32'h0000_0010, 8'd1, 3'd1, 2'b01, 16'h0BAF, 0);
        run_txn(32'h0000_003C, 8'd1, 3'd2, 2'b01, 16'h0F00, 0);

        for (int t = 0; t < 40; t++) begin
            k = $urandom_range(0, 9);
            bt = (k == 0) ? 2'b11 : (k < 4) ? 2'b00 : (k < 7) ? 2'b01 : 2'b10;
            if (bt == 2'b10) begin
                k = $urandom_range(0, 4);
                ln8 = (k == 0) ? 8'd1 : (k == 1) ? 8'd3 : (k == 2) ? 8'd7 : (k == 3) ? 8'd15 : 8'd2;
            end else begin
                ln8 = 8'($urandom_range(0, 12));
            end
            sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
            run_txn($urandom, ln8, sz, bt, 16'($urandom), $urandom_range(0, 2));
        end

        run_txn(32'h0000_0020, 8'd255, 3'd2, 2'b01, 16'h7777, 0);

        // Reset in the middle of a 4-beat burst on the slower instance.
        start_txn(32'h0000_0000, 8'd3, 3'd2, 2'b01, 16'h5555, 0);
        for (int g = 0; g < 200 && beats_done[1] < 2; g++) begin
            tick();
            for (int ln = 0; ln < NLANE; ln++) begin
                if (ar_hs[ln]) arvalid[ln] = 1'b0;
                rready[ln] = 1'b1;
            end
        end
        chk("reached_beat2", 1, 64'(beats_done[1]), 64'(2));
        aresetn = 1'b0;
        #1;
        check_reset_outputs();
        clear_model();
        repeat (2) tick();
        check_reset_outputs();
        aresetn  = 1'b1;
        post_rst = 1'b1;
        run_txn(32'h0000_0014, 8'd0, 3'd2, 2'b01, 16'h4321, 0);
        chk("post_reset_data", 1, 64'(last_rdata[1]), 64'(32'hA5A5_0005));
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
